// File: rtl/stage_fifo_reg.sv
// stage_fifo_reg: elastic pipeline-stage buffer between two CPU stages.
// DEPTH-entry circular buffer with valid/ready on both sides, a synchronous
// flush for redirects, an occupancy output and a saturating stall counter.
// Outputs are driven from registered state only (show-ahead head, no bypass).
module stage_fifo_reg #(
  parameter int unsigned WIDTH = 200,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]    LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

  // Reject out-of-range depths at elaboration time.
  if (DEPTH < 1 || DEPTH > 16) begin : g_depth_check
    $error("stage_fifo_reg: DEPTH must be in 1..16");
  end

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wp;
  logic [PTR_W-1:0]    rp;
  logic [CNT_BITS-1:0] count_q;
  logic [CNT_W-1:0]    stall_q;
  logic                push;
  logic                pop;
  logic                empty;
  logic                full;

  // Explicit wrap at DEPTH-1 so non power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Handshake qualifiers; flush masks both sides so nothing moves that cycle.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == FULL_CNT);
    in_ready  = ~full;
    out_valid = ~empty;
    push      = in_valid & ~full & ~flush;
    pop       = ~empty & out_ready & ~flush;
    count     = count_q;
    stall_cnt = stall_q;
  end

  // Show-ahead head; forced to zero while empty so stale entries never leak.
  always_comb begin
    out_data = '0;
    if (!empty) begin
      out_data = mem[rp];
    end
  end

  // Payload storage; not reset, validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= in_data;
    end
  end

  // Pointer and occupancy update; flush has priority over any transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
    end else if (flush) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wp <= ptr_inc(wp);
      end
      if (pop) begin
        rp <= ptr_inc(rp);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Saturating count of cycles the upstream was blocked; survives flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (in_valid && full && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: doc/stage_fifo_reg.md
Name: stage_fifo_reg

Overview:
- Parametrised successor to the single-entry pipeline stage register.
- Sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries the stage payload.
- Replaces plain write-enable/flush control with a DEPTH-entry elastic buffer using valid/ready handshakes on both sides, plus a synchronous flush.
- Exports occupancy and a saturating stall counter for hazard and performance debug.

Parameters:
WIDTH, 200, payload bits per entry.
DEPTH, 2, entry count; legal range 1..16; need not be a power of two.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
in_valid  in  1  upstream stage presents in_data.
in_ready  out  1  buffer can accept; equals (count < DEPTH).
in_data  in  WIDTH  upstream payload.
out_valid  out  1  head entry is valid; equals (count != 0).
out_ready  in  1  downstream stage consumes the head this cycle.
out_data  out  WIDTH  head entry payload; all zeros when empty.
flush  in  1  synchronous discard of all entries (branch or jump redirect).
count  out  $clog2(DEPTH+1)  current occupancy.
stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0; saturating.

Behaviour:
- Storage: circular array mem[0..DEPTH-1]; write pointer wp and read pointer rp, each in 0..DEPTH-1.
  - Pointers wrap from DEPTH-1 to 0 explicitly; no power-of-two masking.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- On push: mem[wp] <= in_data; wp advances.
- On pop: rp advances.
- count update: count +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop is legal whenever 0 < count < DEPTH; count is unchanged.
- No push is possible when full, because in_ready=0.
- in_ready depends only on registered count. There is no combinational path from out_ready to in_ready.
- out_valid and out_data depend only on registered state (show-ahead head). There is no combinational path from in_* to out_*.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N, i.e. during cycle N+1. Minimum latency is one cycle; there is no bypass.
- Throughput:
  - DEPTH>=2: one word per cycle sustained.
  - DEPTH=1: one word every 2 cycles when out_ready is held high. This is the required, documented degradation.
- Empty: out_valid=0, out_data=0. An out_ready asserted while empty is ignored.
- Full: in_ready=0; in_data is ignored.
  - stall_cnt increments each cycle in_valid=1 while full.
  - stall_cnt holds at 2^CNT_W-1 once reached; it never wraps.
- Flush (synchronous, highest priority):
  - At the edge: wp, rp and count go to 0.
  - Any push or pop in that cycle is discarded.
  - After the edge, out_valid=0 and in_ready=1.
  - stall_cnt is NOT cleared by flush.
  - mem contents need not be cleared, but out_data must read 0 while count=0.
- Reset (reset=0, any time, including mid-transfer):
  - Asynchronously sets wp=rp=count=0 and stall_cnt=0.
  - Outputs during and after reset: out_valid=0, out_data=0, in_ready=1, count=0, stall_cnt=0.
  - The first push is accepted on the first rising edge with reset=1.
- Ordering: strict FIFO; no reordering and no duplication.
- Under any legal stimulus, no entry is lost except by flush or reset.

Test Plan:
- Reset then idle: reset=0 for 3 cycles mid-stream with count=2 → out_valid=0, in_ready=1, count=0, stall_cnt=0 immediately. After release, push 0xA1 → out_data=0xA1 and out_valid=1 the next cycle.
- Back-to-back streaming, DEPTH=2: out_ready=1, push 0x1..0x10 on consecutive cycles → out_data sequence 0x1..0x10 one cycle later, no gaps, count stays ≤1, stall_cnt=0.
- Fill and backpressure, DEPTH=3: out_ready=0, in_valid=1 for 6 cycles with data 0x11..0x16.
  - Accepts 0x11..0x13, then count=3, in_ready=0, stall_cnt=3.
  - Raise out_ready → output order 0x11, 0x12, 0x13, then 0x14 is accepted.
- Wrap-around, DEPTH=3 (non power of two): 10 rounds of push 2 / pop 2 with random gaps → every output matches a reference queue; the pointers pass index 2→0 at least 5 times.
- Flush collision: count=2 and push+pop in the same cycle as flush=1 → next cycle count=0, out_valid=0, out_data=0, in_ready=1; the pushed word never appears; stall_cnt is unchanged.
- DEPTH=1 with CNT_W=4:
  - out_ready=1, continuous in_valid → one accept every 2 cycles.
  - out_ready=0 for 20 cycles with in_valid=1 → stall_cnt saturates at 15 and holds.
